// File: rtl/pm_word_loader_if.sv
// Byte-loader bus: pad-side load stream, program-memory write port and
// CPU result readback grouped into one parametrised bundle.
interface pm_word_loader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADD_WIDTH  = 7,
    parameter int WIDTH      = 8
);
    localparam int BYTES = DATA_WIDTH / WIDTH;
    localparam int LW    = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic                  load_start;
    logic [ADD_WIDTH-1:0]  start_addr;
    logic [WIDTH-1:0]      byte_in;
    logic                  byte_valid;
    logic                  load_end;
    logic                  pm_wr_en;
    logic [ADD_WIDTH-1:0]  pm_addr;
    logic [DATA_WIDTH-1:0] pm_wdata;
    logic                  cpu_hold;
    logic                  busy;
    logic                  load_done;
    logic                  overflow;
    logic [ADD_WIDTH:0]    word_count;
    logic [DATA_WIDTH-1:0] result_in;
    logic [LW-1:0]         result_sel;
    logic [WIDTH-1:0]      result_byte;

    modport master (
        output load_start, start_addr, byte_in, byte_valid, load_end,
               result_in, result_sel,
        input  pm_wr_en, pm_addr, pm_wdata, cpu_hold, busy, load_done,
               overflow, word_count, result_byte
    );

    modport slave (
        input  load_start, start_addr, byte_in, byte_valid, load_end,
               result_in, result_sel,
        output pm_wr_en, pm_addr, pm_wdata, cpu_hold, busy, load_done,
               overflow, word_count, result_byte
    );
endinterface

// File: rtl/pm_word_loader.sv
// Byte-serial program-memory loader: packs pad bytes little-endian into words,
// auto-increments the write address, holds the CPU in reset while loading.
module pm_word_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADD_WIDTH  = 7,
    parameter int WIDTH      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    pm_word_loader_if.slave  bus
);
    localparam int BYTES = DATA_WIDTH / WIDTH;
    localparam int LW    = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    localparam logic [LW-1:0]        LAST_IDX = LW'(BYTES - 1);
    localparam logic [ADD_WIDTH-1:0] ADDR_MAX = '1;

    logic [1:0]            state, state_n;
    logic [ADD_WIDTH-1:0]  addr, addr_n;
    logic [LW-1:0]         byte_idx, byte_idx_n;
    logic [DATA_WIDTH-1:0] assembly, assembly_n;
    logic [ADD_WIDTH:0]    word_count, word_count_n;
    logic                  overflow, overflow_n;
    logic                  top_done, top_done_n;
    logic                  pm_wr_en, pm_wr_en_n;
    logic [ADD_WIDTH-1:0]  pm_addr, pm_addr_n;
    logic [DATA_WIDTH-1:0] pm_wdata, pm_wdata_n;
    logic                  load_done, load_done_n;
    logic [WIDTH-1:0]      result_byte, result_byte_n;

    logic                  commit;
    logic [DATA_WIDTH-1:0] commit_word;
    logic [DATA_WIDTH-1:0] packed_word;

    // NOTE: every variable driven here gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_n      = state;
        addr_n       = addr;
        byte_idx_n   = byte_idx;
        assembly_n   = assembly;
        word_count_n = word_count;
        overflow_n   = overflow;
        top_done_n   = top_done;
        pm_wr_en_n   = 1'b0;
        pm_addr_n    = pm_addr;
        pm_wdata_n   = pm_wdata;
        load_done_n  = 1'b0;
        commit       = 1'b0;
        commit_word  = '0;

        packed_word = assembly;
        for (int k = 0; k < BYTES; k++) begin
            if (int'(byte_idx) == k) packed_word[k*WIDTH +: WIDTH] = bus.byte_in;
        end

        if (bus.load_start) begin
            // Restart from any state; partial word and pending flush are dropped.
            state_n      = ST_LOAD;
            addr_n       = bus.start_addr;
            byte_idx_n   = '0;
            assembly_n   = '0;
            word_count_n = '0;
            overflow_n   = 1'b0;
            top_done_n   = 1'b0;
        end else begin
            case (state)
                ST_IDLE: ;
                ST_LOAD: begin
                    if (bus.byte_valid) begin
                        if (byte_idx == LAST_IDX) begin
                            commit      = 1'b1;
                            commit_word = packed_word;
                            byte_idx_n  = '0;
                            assembly_n  = '0;
                        end else begin
                            byte_idx_n  = byte_idx + LW'(1);
                            assembly_n  = packed_word;
                        end
                    end
                    if (bus.load_end) begin
                        if (byte_idx_n != '0) begin
                            state_n = ST_FLUSH;
                        end else begin
                            state_n     = ST_IDLE;
                            load_done_n = 1'b1;
                        end
                    end
                end
                ST_FLUSH: begin
                    // Unfilled lanes are already zero: assembly is cleared per word.
                    commit      = 1'b1;
                    commit_word = assembly;
                    byte_idx_n  = '0;
                    assembly_n  = '0;
                    state_n     = ST_IDLE;
                    load_done_n = 1'b1;
                end
                default: state_n = ST_IDLE;
            endcase
        end

        // Once the top address has been written, further words are dropped
        // and flagged rather than wrapping onto low memory.
        if (commit) begin
            if (top_done) begin
                overflow_n = 1'b1;
            end else begin
                pm_wr_en_n   = 1'b1;
                pm_addr_n    = addr;
                pm_wdata_n   = commit_word;
                word_count_n = word_count + (ADD_WIDTH+1)'(1);
                if (addr == ADDR_MAX) top_done_n = 1'b1;
                else                  addr_n     = addr + ADD_WIDTH'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            addr       <= '0;
            byte_idx   <= '0;
            assembly   <= '0;
            word_count <= '0;
            overflow   <= 1'b0;
            top_done   <= 1'b0;
            pm_wr_en   <= 1'b0;
            pm_addr    <= '0;
            pm_wdata   <= '0;
            load_done  <= 1'b0;
        end else begin
            state      <= state_n;
            addr       <= addr_n;
            byte_idx   <= byte_idx_n;
            assembly   <= assembly_n;
            word_count <= word_count_n;
            overflow   <= overflow_n;
            top_done   <= top_done_n;
            pm_wr_en   <= pm_wr_en_n;
            pm_addr    <= pm_addr_n;
            pm_wdata   <= pm_wdata_n;
            load_done  <= load_done_n;
        end
    end

    // Result readback runs every cycle regardless of the load FSM.
    always_comb begin
        result_byte_n = '0;
        for (int k = 0; k < BYTES; k++) begin
            if (int'(bus.result_sel) == k) result_byte_n = bus.result_in[k*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) result_byte <= '0;
        else        result_byte <= result_byte_n;
    end

    assign bus.pm_wr_en    = pm_wr_en;
    assign bus.pm_addr     = pm_addr;
    assign bus.pm_wdata    = pm_wdata;
    assign bus.busy        = (state != ST_IDLE);
    assign bus.cpu_hold    = (state != ST_IDLE);
    assign bus.load_done   = load_done;
    assign bus.overflow    = overflow;
    assign bus.word_count  = word_count;
    assign bus.result_byte = result_byte;

endmodule

// File: tb/tb_pm_word_loader.sv
// Self-checking bench for pm_word_loader: table-driven loads and readback,
// hand-written corner sequences, and a write scoreboard.
module tb_pm_word_loader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pm_word_loader_if #(.DATA_WIDTH(32), .ADD_WIDTH(7), .WIDTH(8)) bus ();

    pm_word_loader #(.DATA_WIDTH(32), .ADD_WIDTH(7), .WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [6:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [6:0]  start_addr;
        logic [7:0]  b0, b1, b2, b3;
        logic [31:0] exp_word;
    } load_vec_t;

    typedef struct {
        logic [31:0] result_in;
        logic [1:0]  sel;
        logic [7:0]  exp_byte;
    } rb_vec_t;

    wr_t exp_q[$];
    int  tests  = 0;
    int  failed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [6:0] a);
        bus.load_start = 1'b1;
        bus.start_addr = a;
        step();
        bus.load_start = 1'b0;
    endtask

    task automatic pulse_end();
        bus.load_end = 1'b1;
        step();
        bus.load_end = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.byte_valid = 1'b1;
        bus.byte_in    = b;
        step();
        bus.byte_valid = 1'b0;
    endtask

    task automatic expect_write(input logic [6:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Scoreboard: every write strobe must match the oldest expected write.
    always @(posedge clk) begin
        #1;
        if (bus.pm_wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, required no write (t=%0t)",
                         bus.pm_addr, bus.pm_wdata, $time);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 64'(bus.pm_addr), 64'(e.addr));
                check("wr_data", 64'(bus.pm_wdata), 64'(e.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    load_vec_t load_tbl[3];
    rb_vec_t   rb_tbl[5];

    initial begin
        load_tbl[0] = '{7'h10, 8'h13, 8'h05, 8'h50, 8'h00, 32'h0050_0513};
        load_tbl[1] = '{7'h01, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 32'hDEAD_BEEF};
        load_tbl[2] = '{7'h7E, 8'hFF, 8'h00, 8'hFF, 8'h00, 32'h00FF_00FF};

        rb_tbl[0] = '{32'hDEAD_BEEF, 2'd2, 8'hAD};
        rb_tbl[1] = '{32'hDEAD_BEEF, 2'd0, 8'hEF};
        rb_tbl[2] = '{32'hDEAD_BEEF, 2'd1, 8'hBE};
        rb_tbl[3] = '{32'hDEAD_BEEF, 2'd3, 8'hDE};
        rb_tbl[4] = '{32'h1234_5678, 2'd3, 8'h12};

        bus.load_start = 1'b0;
        bus.start_addr = '0;
        bus.byte_in    = '0;
        bus.byte_valid = 1'b0;
        bus.load_end   = 1'b0;
        bus.result_in  = '0;
        bus.result_sel = '0;

        // Reset state
        step();
        step();
        check("rst_busy",       64'(bus.busy),       64'd0);
        check("rst_cpu_hold",   64'(bus.cpu_hold),   64'd0);
        check("rst_pm_wr_en",   64'(bus.pm_wr_en),   64'd0);
        check("rst_word_count", 64'(bus.word_count), 64'd0);
        check("rst_overflow",   64'(bus.overflow),   64'd0);
        rst_n = 1'b1;
        step();

        // byte_valid in IDLE is ignored
        send_byte(8'h55);
        check("idle_busy", 64'(bus.busy), 64'd0);

        // Table-driven single-word loads
        for (int i = 0; i < 3; i++) begin
            pulse_start(load_tbl[i].start_addr);
            check("ld_busy_after_start", 64'(bus.busy), 64'd1);
            check("ld_wc_after_start",   64'(bus.word_count), 64'd0);
            expect_write(load_tbl[i].start_addr, load_tbl[i].exp_word);
            send_byte(load_tbl[i].b0);
            send_byte(load_tbl[i].b1);
            send_byte(load_tbl[i].b2);
            check("ld_hold_mid", 64'(bus.cpu_hold), 64'd1);
            send_byte(load_tbl[i].b3);
            check("ld_wr_strobe", 64'(bus.pm_wr_en), 64'd1);
            check("ld_word_count", 64'(bus.word_count), 64'd1);
            check("ld_hold_end", 64'(bus.cpu_hold), 64'd1);
            step();
            check("ld_wr_one_cycle", 64'(bus.pm_wr_en), 64'd0);
            pulse_end();
            check("ld_done",      64'(bus.load_done), 64'd1);
            check("ld_hold_drop", 64'(bus.cpu_hold),  64'd0);
            check("ld_busy_drop", 64'(bus.busy),      64'd0);
            step();
            check("ld_done_pulse", 64'(bus.load_done), 64'd0);
        end

        // Partial word flushed zero-padded
        pulse_start(7'h30);
        send_byte(8'hAA);
        send_byte(8'hBB);
        expect_write(7'h30, 32'h0000_BBAA);
        pulse_end();
        check("fl_busy_in_flush", 64'(bus.busy), 64'd1);
        check("fl_no_done_yet",   64'(bus.load_done), 64'd0);
        step();
        check("fl_wr_strobe", 64'(bus.pm_wr_en),  64'd1);
        check("fl_done",      64'(bus.load_done), 64'd1);
        check("fl_hold",      64'(bus.cpu_hold),  64'd0);
        check("fl_busy",      64'(bus.busy),      64'd0);

        // Two back-to-back words: address increments, byte in write cycle kept
        pulse_start(7'h40);
        expect_write(7'h40, 32'h4433_2211);
        expect_write(7'h41, 32'h8877_6655);
        for (int i = 0; i < 8; i++) send_byte(8'h11 * 8'(i + 1));
        check("bb_word_count", 64'(bus.word_count), 64'd2);
        pulse_end();
        check("bb_done", 64'(bus.load_done), 64'd1);

        // Top address: second word suppressed, overflow sticky
        pulse_start(7'h7F);
        expect_write(7'h7F, 32'h0302_0100);
        for (int i = 0; i < 8; i++) send_byte(8'(i));
        pulse_end();
        check("ov_overflow",   64'(bus.overflow),   64'd1);
        check("ov_word_count", 64'(bus.word_count), 64'd1);
        check("ov_done",       64'(bus.load_done),  64'd1);
        step();
        check("ov_sticky", 64'(bus.overflow), 64'd1);

        // Restart mid-word; byte in the restart cycle is dropped
        pulse_start(7'h50);
        check("rs_overflow_cleared", 64'(bus.overflow), 64'd0);
        send_byte(8'hC1);
        send_byte(8'hC2);
        bus.byte_valid = 1'b1;
        bus.byte_in    = 8'h99;
        pulse_start(7'h20);
        bus.byte_valid = 1'b0;
        expect_write(7'h20, 32'h0403_0201);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        pulse_end();
        check("rs_overflow", 64'(bus.overflow),   64'd0);
        check("rs_wc",       64'(bus.word_count), 64'd1);

        // Restart during FLUSH cancels the flush; load_start beats load_end
        pulse_start(7'h60);
        send_byte(8'h11);
        pulse_end();
        check("fc_in_flush", 64'(bus.busy), 64'd1);
        bus.load_end = 1'b1;
        pulse_start(7'h61);
        bus.load_end = 1'b0;
        check("fc_busy",    64'(bus.busy),      64'd1);
        check("fc_no_done", 64'(bus.load_done), 64'd0);
        pulse_end();
        check("fc_done",    64'(bus.load_done),  64'd1);
        check("fc_wc",      64'(bus.word_count), 64'd0);

        // Asynchronous reset mid-session
        pulse_start(7'h08);
        send_byte(8'hA1);
        send_byte(8'hA2);
        send_byte(8'hA3);
        rst_n = 1'b0;
        #1;
        check("ar_busy",     64'(bus.busy),     64'd0);
        check("ar_hold",     64'(bus.cpu_hold), 64'd0);
        check("ar_pm_addr",  64'(bus.pm_addr),  64'd0);
        check("ar_pm_wdata", 64'(bus.pm_wdata), 64'd0);
        send_byte(8'hA4);
        step();
        rst_n = 1'b1;
        step();

        // Load after reset, load_end coinciding with the completing byte
        pulse_start(7'h05);
        expect_write(7'h05, 32'h1234_5678);
        send_byte(8'h78);
        send_byte(8'h56);
        send_byte(8'h34);
        bus.load_end = 1'b1;
        send_byte(8'h12);
        bus.load_end = 1'b0;
        check("le_wr_strobe", 64'(bus.pm_wr_en),  64'd1);
        check("le_done",      64'(bus.load_done), 64'd1);
        check("le_busy",      64'(bus.busy),      64'd0);

        // Readback table: registered lane select, one-cycle latency
        for (int i = 0; i < 5; i++) begin
            bus.result_in  = rb_tbl[i].result_in;
            bus.result_sel = rb_tbl[i].sel;
            step();
            check("readback", 64'(bus.result_byte), 64'(rb_tbl[i].exp_byte));
        end

        step();
        step();
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
